// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared types and helpers for the RV32I instruction encoder.
package rv32i_instr_encoder_pkg;

  typedef enum logic [6:0] {
    STALL         = 7'b0000000,
    LOAD          = 7'b0000011,
    IMM_OPERATION = 7'b0010011,
    AUIPC         = 7'b0010111,
    STORE         = 7'b0100011,
    REG_OPERATION = 7'b0110011,
    LUI           = 7'b0110111,
    BRANCH        = 7'b1100011,
    JALR          = 7'b1100111,
    JAL           = 7'b1101111
  } opcode_fmt_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NOP, FMT_BAD
  } instr_fmt_t;

  localparam logic [31:0] Nop = 32'h0000_0013;

  function automatic instr_fmt_t opcode_to_fmt(input logic [6:0] op);
    instr_fmt_t f;
    case (op)
      REG_OPERATION:             f = FMT_R;
      IMM_OPERATION, LOAD, JALR: f = FMT_I;
      STORE:                     f = FMT_S;
      BRANCH:                    f = FMT_B;
      LUI, AUIPC:                f = FMT_U;
      JAL:                       f = FMT_J;
      STALL:                     f = FMT_NOP;
      default:                   f = FMT_BAD;
    endcase
    return f;
  endfunction

  // True when v, read as signed, is representable in n signed bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi;
    hi = $signed(v) >>> (n - 32'd1);
    return (hi == 32'd0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Field-bundle input, encoded-word output and address-config signals of the encoder.
interface rv32i_instr_encoder_if #(
  parameter int AddrWidth = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [31:0]          in_imm;
  logic                 cfg_base_we;
  logic [AddrWidth-1:0] cfg_base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [AddrWidth-1:0] out_addr;
  logic                 out_err;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
           cfg_base_we, cfg_base, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
           cfg_base_we, cfg_base, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/rv32i_instr_encoder_skid_buffer.sv
// Two-entry valid/ready register slice: output register plus one skid entry,
// ready registered and equal to skid-empty.
module rv32i_skid_buffer #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic [Width-1:0] out_data_q, out_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             in_fire_s;

  assign in_fire_s = in_valid_i & in_ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees up: skid drains first to keep order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire_s;
        if (in_fire_s) out_data_d = in_data_i;
        else           out_data_d = out_data_q;
      end
    end else begin
      if (in_fire_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields into a 32-bit word with a byte address.
// Optional field range checking is built when RV32I_ENCODER_CHECK_EN is defined.
module rv32i_instr_encoder
  import rv32i_instr_encoder_pkg::*;
#(
  parameter int                   AddrWidth = 32,
  parameter logic [AddrWidth-1:0] ResetAddr = '0
) (
  input logic                   clk,
  input logic                   rst,
  rv32i_instr_encoder_if.slave  bus
);
  localparam int Width = 32 + AddrWidth + 1;

  instr_fmt_t           fmt_s;
  logic                 shift_s;
  logic [31:0]          instr_s;
  logic                 err_s;
  logic [AddrWidth-1:0] addr_s;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 in_ready_s;
  logic                 in_fire_s;
  logic [Width-1:0]     out_data_s;

  logic [6:0]  op_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_s;

  assign op_s  = bus.in_opcode;
  assign rd_s  = bus.in_rd;
  assign rs1_s = bus.in_rs1;
  assign rs2_s = bus.in_rs2;
  assign f3_s  = bus.in_funct3;
  assign f7_s  = bus.in_funct7;
  assign imm_s = bus.in_imm;

  assign fmt_s   = opcode_to_fmt(op_s);
  // SLLI/SRLI/SRAI (funct3 001/101) carry funct7 and a 5-bit shamt.
  assign shift_s = (op_s == IMM_OPERATION) && (f3_s[1:0] == 2'b01);

  always_comb begin
    instr_s = Nop;
    case (fmt_s)
      FMT_R: instr_s = {f7_s, rs2_s, rs1_s, f3_s, rd_s, op_s};
      FMT_I: begin
        if (shift_s) instr_s = {f7_s, imm_s[4:0], rs1_s, f3_s, rd_s, op_s};
        else         instr_s = {imm_s[11:0], rs1_s, f3_s, rd_s, op_s};
      end
      FMT_S: instr_s = {imm_s[11:5], rs2_s, rs1_s, f3_s, imm_s[4:0], op_s};
      FMT_B: instr_s = {imm_s[12], imm_s[10:5], rs2_s, rs1_s, f3_s,
                        imm_s[4:1], imm_s[11], op_s};
      FMT_U: instr_s = {imm_s[31:12], rd_s, op_s};
      FMT_J: instr_s = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], rd_s, op_s};
      default: instr_s = Nop;
    endcase
  end

`ifdef RV32I_ENCODER_CHECK_EN
  always_comb begin
    err_s = 1'b0;
    case (fmt_s)
      FMT_I: begin
        if (shift_s) err_s = (imm_s > 32'd31);
        else         err_s = !fits_signed(imm_s, 32'd12);
      end
      FMT_S:   err_s = !fits_signed(imm_s, 32'd12);
      FMT_B:   err_s = !fits_signed(imm_s, 32'd13) || imm_s[0];
      FMT_J:   err_s = !fits_signed(imm_s, 32'd21) || imm_s[0];
      FMT_U:   err_s = (imm_s[11:0] != 12'd0);
      FMT_BAD: err_s = 1'b1;
      default: err_s = 1'b0;
    endcase
  end
`else
  assign err_s = 1'b0;
`endif

  assign in_fire_s = bus.in_valid & in_ready_s;

  // A base write coinciding with an accept applies to that very word.
  always_comb begin
    addr_s = bus.cfg_base_we ? bus.cfg_base : cnt_q;
    if (in_fire_s)             cnt_d = addr_s + AddrWidth'(4);
    else if (bus.cfg_base_we)  cnt_d = bus.cfg_base;
    else                       cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= ResetAddr;
    else     cnt_q <= cnt_d;
  end

  rv32i_skid_buffer #(
    .Width (Width)
  ) u_slice (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (in_ready_s),
    .in_data_i   ({instr_s, addr_s, err_s}),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_data_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_instr = out_data_s[Width-1 -: 32];
  assign bus.out_addr  = out_data_s[AddrWidth:1];
  assign bus.out_err   = out_data_s[0];
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: field-level reference encoder plus in-order scoreboard.
module tb_rv32i_instr_encoder;
  import rv32i_instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef RV32I_ENCODER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  always #5 clk = ~clk;

  rv32i_instr_encoder_if #(.AddrWidth(32)) bus ();

  rv32i_instr_encoder #(.AddrWidth(32), .ResetAddr(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mcnt = 32'h0;
  bit          hold_v = 1'b0;
  exp_t        held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] at(input bit [31:0] v, input int lo);
    return v << lo;
  endfunction

  function automatic bit [31:0] bits(input bit [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder assembled field by field from the ISA bit positions.
  function automatic logic [31:0] model_word(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    bit [31:0] u = imm;
    bit [31:0] regs = at(f3, 12) | at(rs1, 15);
    case (op)
      REG_OPERATION: return op | at(rd, 7) | regs | at(rs2, 20) | at(f7, 25);
      IMM_OPERATION: begin
        if (f3 == 3'd1 || f3 == 3'd5) return op | at(rd, 7) | regs | at(bits(u, 4, 0), 20) | at(f7, 25);
        return op | at(rd, 7) | regs | at(bits(u, 11, 0), 20);
      end
      LOAD, JALR:    return op | at(rd, 7) | regs | at(bits(u, 11, 0), 20);
      STORE:         return op | at(bits(u, 4, 0), 7) | regs | at(rs2, 20) | at(bits(u, 11, 5), 25);
      BRANCH:        return op | at(bits(u, 11, 11), 7) | at(bits(u, 4, 1), 8) | regs | at(rs2, 20)
                            | at(bits(u, 10, 5), 25) | at(bits(u, 12, 12), 31);
      LUI, AUIPC:    return (u & 32'hFFFF_F000) | at(rd, 7) | op;
      JAL:           return op | at(rd, 7) | at(bits(u, 19, 12), 12) | at(bits(u, 11, 11), 20)
                            | at(bits(u, 10, 1), 21) | at(bits(u, 20, 20), 31);
      default:       return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic model_err(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm);
    int s = $signed(imm);
    if (!ChkEn) return 1'b0;
    case (op)
      IMM_OPERATION: begin
        if (f3 == 3'd1 || f3 == 3'd5) return imm > 32'd31;
        return s < -2048 || s > 2047;
      end
      LOAD, JALR, STORE: return s < -2048 || s > 2047;
      BRANCH:            return s < -4096 || s > 4095 || imm[0];
      JAL:               return s < -1048576 || s > 1048575 || imm[0];
      LUI, AUIPC:        return imm[11:0] != 12'd0;
      REG_OPERATION, STALL: return 1'b0;
      default:           return 1'b1;
    endcase
  endfunction

  // Occupancy of the DUT equals the number of scoreboard entries in flight.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mcnt   = 32'h0;
      hold_v = 1'b0;
    end else begin
      check("in_ready_vs_occupancy", bus.in_ready, sb.size() < 2);
      check("out_valid_vs_occupancy", bus.out_valid, sb.size() != 0);
      if (hold_v) begin
        check("hold_instr", bus.out_instr, held.instr);
        check("hold_addr", bus.out_addr, held.addr);
        check("hold_err", bus.out_err, held.err);
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_instr", bus.out_instr, e.instr);
        check("out_addr", bus.out_addr, e.addr);
        check("out_err", bus.out_err, e.err);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.addr  = bus.cfg_base_we ? bus.cfg_base : mcnt;
        e.instr = model_word(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                             bus.in_funct3, bus.in_funct7, bus.in_imm);
        e.err   = model_err(bus.in_opcode, bus.in_funct3, bus.in_imm);
        mcnt    = e.addr + 32'd4;
        sb.push_back(e);
      end else if (bus.cfg_base_we) begin
        mcnt = bus.cfg_base;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      held.instr = bus.out_instr;
      held.addr  = bus.out_addr;
      held.err   = bus.out_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      acc = bus.in_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    bus.in_valid    = 1'b0;
    bus.cfg_base_we = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input logic we = 1'b0, input logic [31:0] base = 32'h0);
    bus.in_opcode = op;  bus.in_rd = rd;  bus.in_rs1 = rs1;  bus.in_rs2 = rs2;
    bus.in_funct3 = f3;  bus.in_funct7 = f7;  bus.in_imm = imm;
    bus.cfg_base_we = we;  bus.cfg_base = base;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input logic we = 1'b0, input logic [31:0] base = 32'h0);
    drive(op, rd, rs1, rs2, f3, f7, imm, we, base);
    wait_accept();
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && bus.out_valid; k++) tick();
    check("drain_timeout", bus.out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;  bus.in_opcode = 7'd0;  bus.in_rd = 5'd0;  bus.in_rs1 = 5'd0;
    bus.in_rs2 = 5'd0;  bus.in_funct3 = 3'd0;  bus.in_funct7 = 7'd0;  bus.in_imm = 32'd0;
    bus.cfg_base_we = 1'b0;  bus.cfg_base = 32'd0;  bus.out_ready = 1'b1;

    // Pin the reference encoder to hand-computed words.
    check("model_add",  model_word(REG_OPERATION, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0), 32'h002081B3);
    check("model_addi", model_word(IMM_OPERATION, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), 32'hFFF00093);
    check("model_sw",   model_word(STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), 32'h0020A423);
    check("model_lui",  model_word(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), 32'h123452B7);
    check("model_beq",  model_word(BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC), 32'hFE000EE3);
    check("model_jal",  model_word(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8), 32'h008000EF);
    check("model_srai", model_word(IMM_OPERATION, 5'd2, 5'd3, 5'd0, 3'd5, 7'h20, 32'd5), 32'h4051D113);

    do_reset();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_addr", bus.out_addr, 32'h0);
    check("rst_out_err", bus.out_err, 1'b0);

    // Single word, one-cycle latency, first address.
    send(REG_OPERATION, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("t1_valid", bus.out_valid, 1'b1);
    check("t1_instr", bus.out_instr, 32'h002081B3);
    check("t1_addr", bus.out_addr, 32'h0);

    send(IMM_OPERATION, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    check("t2_addi", bus.out_instr, 32'hFFF00093);
    check("t2_addi_addr", bus.out_addr, 32'h4);
    send(STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send(BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    check("t3_beq", bus.out_instr, 32'hFE000EE3);
    send(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    send(STALL, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF);
    check("t3_stall", bus.out_instr, 32'h0000_0013);
    drain();

    // Backpressure: third word waits until the slice drains.
    do_reset();
    bus.out_ready = 1'b0;
    send(REG_OPERATION, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(IMM_OPERATION, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    drive(STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    tick();
    check("t4_ready_low", bus.in_ready, 1'b0);
    check("t4_head_instr", bus.out_instr, 32'h002081B3);
    check("t4_head_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("t4_second_addr", bus.out_addr, 32'h4);
    wait_accept();
    check("t4_third_addr", bus.out_addr, 32'h8);
    drain();

    // Base load with accept, then wrap.
    send(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'hFFFF_FFFC);
    check("t5_base_addr", bus.out_addr, 32'hFFFF_FFFC);
    send(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    check("t5_wrap_addr", bus.out_addr, 32'h0);
    drain();

    // Reset mid-stream with two words buffered.
    bus.out_ready = 1'b0;
    send(BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send(STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_valid", bus.out_valid, 1'b0);
    check("t6_in_ready", bus.in_ready, 1'b1);
    send(IMM_OPERATION, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("t6_counter_reset", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    drain();

    // Range boundary for ADDI.
    send(IMM_OPERATION, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    check("t7_err_2048", bus.out_err, ChkEn);
    check("t7_instr_2048", bus.out_instr, 32'h80010093);
    send(IMM_OPERATION, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2047);
    check("t7_err_2047", bus.out_err, 1'b0);
    drain();

    // Mixed formats under a varying sink.
    fork
      begin
        send(IMM_OPERATION, 5'd2, 5'd3, 5'd0, 3'd5, 7'h20, 32'd5);
        send(IMM_OPERATION, 5'd2, 5'd3, 5'd0, 3'd1, 7'h00, 32'd40);
        send(LOAD, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800);
        send(JALR, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0);
        send(AUIPC, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE123);
        send(BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, 32'd4094);
        send(BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, 32'd4097);
        send(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
        send(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        send(STORE, 5'd0, 5'd10, 5'd11, 3'd0, 7'd0, 32'hFFFF_F7FF);
        send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1);
        send(REG_OPERATION, 5'd31, 5'd30, 5'd29, 3'd5, 7'h20, 32'd0);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("final_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
